sram_bus_master: RTL and testbench
==================================

// Module: sram_bus_master
// PURPOSE
//  Initiator for the 8x16 synchronous single-port RAM with the shared inout data bus.
//  Accepts write and read-burst requests over a valid/ready handshake.
//  Drives the RAM's we/re/address lines and owns bus direction, with a turnaround cycle after reads.
//  Returns read data as a response stream. Sits between datapath logic and the RAM instance.
// PARAMETERS
//  DW   16  data width; equals RAM word width
//  AW   3   address width; RAM depth = 2**AW = 8
// PORTS
//  clk          in     1   clock, all logic on posedge
//  rst          in     1   reset, synchronous, active-high (shared with RAM)
//  req_valid    in     1   request present
//  req_ready    out    1   request accepted when req_valid&&req_ready at posedge
//  req_write    in     1   1 = single-word write, 0 = read burst
//  req_addr     in     AW  write address / burst start address
//  req_len      in     AW  read beats minus 1 (0 -> 1 beat, 7 -> 8 beats); ignored on writes
//  req_wdata    in     DW  write data
//  rsp_valid    out    1   one read word valid this cycle; no backpressure
//  rsp_last     out    1   final beat of burst, qualified by rsp_valid
//  rsp_rdata    out    DW  read word
//  ram_we       out    1   RAM write enable
//  ram_re       out    1   RAM read enable
//  ram_w_addr   out    AW  RAM write address
//  ram_r_addr   out    AW  RAM read address
//  ram_data     inout  DW  shared bus; driven only in WR state, else 'z
// BEHAVIOUR
//  States: IDLE, WR, RD, DRAIN, TURN. req_ready = (state==IDLE) && !rst.
//  Reset: state IDLE; ram_we=ram_re=0; addrs=0; bus 'z; rsp_valid=rsp_last=0; rsp_rdata=0.
//  Reset mid-operation aborts it. No further rsp_valid for the aborted burst.
//  IDLE, accept write -> WR for 1 cycle:
//   ram_we=1, ram_re=0, ram_w_addr=req_addr, bus=req_wdata.
//   RAM stores the word at the end of WR, then back to IDLE.
//  IDLE, accept read -> RD:
//   Latch base=req_addr and beats=req_len+1.
//   RD beat k (k=0..beats-1): ram_re=1, ram_we=0, ram_r_addr=(base+k) mod 8.
//   Wrap-around is natural AW-bit overflow.
//  After the last RD beat -> DRAIN for 1 cycle: ram_re=1, ram_r_addr holds last address.
//  DRAIN -> TURN for 1 cycle: ram_re=0, ram_we=0, bus 'z. Then IDLE.
//  Read data capture:
//   RAM presents mem[addr] on the bus in the cycle after that address was issued.
//   Bus is sampled at the end of RD beats 1..beats-1 and at the end of DRAIN.
//   The value seen during RD beat 0 is stale and is discarded.
//   rsp_valid/rsp_rdata are registered, so beat k appears 2 cycles after its address cycle.
//   Beats are consecutive cycles. rsp_last is set on beat beats-1, which coincides with TURN.
//  Latency: first rsp_valid in the 3rd cycle after the accepting edge.
//   Read occupancy = beats+2 cycles. Write occupancy = 1 cycle, with an IDLE cycle between requests.
//  Invariants:
//   ram_we && ram_re never both 1.
//   Master drives the bus only when ram_we=1.
//   At least one cycle with both enables low between any read and the next write (TURN).
//  Requests presented while busy are held off (req_ready=0). Inputs are sampled only on accept.
// TESTING
//  1. rst held 2 cycles -> all outputs at reset values, bus 'z, req_ready=1 after release.
//  2. write addr 3 = 16'hA5A5, then read addr 3 len 0
//     -> one rsp_valid with rdata A5A5, rsp_last=1, 3rd cycle after read accept.
//  3. write addrs 0..7 with 16'h1000+i; read base 6 len 7
//     -> 8 beats in order 1006,1007,1000..1005; rsp_last on the 8th beat only.
//  4. read len 3 immediately followed by a write
//     -> write accepted only after TURN; bus never X/contended; ram_we&ram_re never both 1.
//  5. assert rst in 2nd RD beat of a len 7 burst -> no further rsp_valid; IDLE next cycle.
//     Subsequent reads return 0, because the RAM is also cleared.
//  6. req_valid held high with alternating write/read requests
//     -> req_ready pulses only in IDLE; each request accepted exactly once.

Source files
------------

// File: rtl/sram_bus_master_if.sv
// Request/response stream between datapath logic and the SRAM bus master.
// The requester takes the master modport; sram_bus_master takes the slave modport.
interface sram_bus_master_if #(
   parameter int DW = 16,
   parameter int AW = 3
);
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [AW-1:0] req_len;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_last;
   logic [DW-1:0] rsp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_len, req_wdata,
      input  req_ready, rsp_valid, rsp_last, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_len, req_wdata,
      output req_ready, rsp_valid, rsp_last, rsp_rdata
   );
endinterface

// File: rtl/sram_bus_master.sv
// Initiator for an 8x16 synchronous single-port RAM with a shared inout data bus.
// Serves single-word writes and wrapping read bursts; returns read words as a stream.
module sram_bus_master #(
   parameter int DW = 16,
   parameter int AW = 3
) (
   input  logic             clk,
   input  logic             rst,
   sram_bus_master_if.slave req_if,
   output logic             ram_we,
   output logic             ram_re,
   output logic [AW-1:0]    ram_w_addr,
   output logic [AW-1:0]    ram_r_addr,
   inout  wire  [DW-1:0]    ram_data
);

   localparam logic [2:0]    S_IDLE    = 3'd0;
   localparam logic [2:0]    S_WR      = 3'd1;
   localparam logic [2:0]    S_RD      = 3'd2;
   localparam logic [2:0]    S_DRAIN   = 3'd3;
   localparam logic [2:0]    S_TURN    = 3'd4;
   localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
   localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   logic [2:0]    state_q,     state_d;
   logic          we_q,        we_d;
   logic          re_q,        re_d;
   logic [AW-1:0] w_addr_q,    w_addr_d;
   logic [AW-1:0] r_addr_q,    r_addr_d;
   logic [DW-1:0] wdata_q,     wdata_d;
   logic [AW-1:0] cnt_q,       cnt_d;
   logic          first_q,     first_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_last_q,  rsp_last_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic          accept_s;

   assign req_if.req_ready = (state_q == S_IDLE) && !rst;
   assign accept_s         = req_if.req_valid && req_if.req_ready;

   // Next-state and registered RAM/response outputs; outputs are computed for the upcoming state.
   always_comb begin
      state_d     = state_q;
      we_d        = 1'b0;
      re_d        = 1'b0;
      w_addr_d    = w_addr_q;
      r_addr_d    = r_addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      first_d     = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_last_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               if (req_if.req_write) begin
                  state_d  = S_WR;
                  we_d     = 1'b1;
                  w_addr_d = req_if.req_addr;
                  wdata_d  = req_if.req_wdata;
               end else begin
                  state_d  = S_RD;
                  re_d     = 1'b1;
                  r_addr_d = req_if.req_addr;
                  cnt_d    = req_if.req_len;
                  first_d  = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WR: begin
            state_d = S_IDLE;
         end
         S_RD: begin
            // The bus during beat 0 still carries whatever preceded the burst, so skip it.
            re_d        = 1'b1;
            rsp_valid_d = !first_q;
            if (cnt_q == ADDR_ZERO) begin
               state_d = S_DRAIN;
            end else begin
               cnt_d    = cnt_q - ADDR_ONE;
               r_addr_d = r_addr_q + ADDR_ONE;
            end
         end
         S_DRAIN: begin
            state_d     = S_TURN;
            rsp_valid_d = 1'b1;
            rsp_last_d  = 1'b1;
         end
         S_TURN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (rsp_valid_d) begin
         rsp_rdata_d = ram_data;
      end else begin
         rsp_rdata_d = rsp_rdata_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         re_q        <= 1'b0;
         w_addr_q    <= ADDR_ZERO;
         r_addr_q    <= ADDR_ZERO;
         wdata_q     <= {DW{1'b0}};
         cnt_q       <= ADDR_ZERO;
         first_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_rdata_q <= {DW{1'b0}};
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         re_q        <= re_d;
         w_addr_q    <= w_addr_d;
         r_addr_q    <= r_addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         first_q     <= first_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_last_q  <= rsp_last_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign ram_we           = we_q;
   assign ram_re           = re_q;
   assign ram_w_addr       = w_addr_q;
   assign ram_r_addr       = r_addr_q;
   assign ram_data         = we_q ? wdata_q : {DW{1'bz}};
   assign req_if.rsp_valid = rsp_valid_q;
   assign req_if.rsp_last  = rsp_last_q;
   assign req_if.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sram_bus_master.sv
// Scoreboard bench for sram_bus_master with a behavioural RAM on the shared bus.
module tb_sram_bus_master;

   typedef struct {
      logic [15:0] d;
      logic        l;
      int          c;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        ram_we;
   logic        ram_re;
   logic [2:0]  ram_w_addr;
   logic [2:0]  ram_r_addr;
   wire  [15:0] ram_data;

   sram_bus_master_if #(.DW(16), .AW(3)) bus_if ();

   sram_bus_master #(.DW(16), .AW(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_if     (bus_if),
      .ram_we     (ram_we),
      .ram_re     (ram_re),
      .ram_w_addr (ram_w_addr),
      .ram_r_addr (ram_r_addr),
      .ram_data   (ram_data)
   );

   // RAM: cleared by rst, writes at the edge, read data on the bus the cycle after re.
   logic [15:0] ram_mem [0:7];
   logic [15:0] ram_out_q;
   logic        ram_drv_q;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) ram_mem[i] <= 16'h0000;
         ram_out_q <= 16'h0000;
         ram_drv_q <= 1'b0;
      end else begin
         if (ram_we) ram_mem[ram_w_addr] <= ram_data;
         if (ram_re) begin
            ram_out_q <= ram_mem[ram_r_addr];
            ram_drv_q <= 1'b1;
         end else begin
            ram_drv_q <= 1'b0;
         end
      end
   end

   assign ram_data = ram_drv_q ? ram_out_q : 16'bz;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nvec = 0;
   int nmis = 0;
   int ndrv = 0;
   int ntmo = 0;
   int nacc = 0;
   bit end_req = 1'b0;

   // Reference model state
   logic [15:0] ref_mem [0:7];
   exp_t        sb_q [$];
   exp_t        e;
   bit          armed = 1'b0;
   int          free_cyc = 0;
   int          wr_cyc = -1;
   logic [2:0]  wr_addr_exp;
   logic [15:0] wr_data_exp;
   int          rd_from = -1;
   int          rd_to = -2;
   int          rd_beats = 1;
   int          rd_base = 0;
   int          rst_edge_cyc = -1;
   int          a_cyc;
   int          k_s;
   bit          re_exp;

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: protocol checks and scoreboard pops on the falling edge.
   always @(negedge clk) begin
      if (armed) begin
         chk("req_ready", int'(bus_if.req_ready), int'(!rst && (cyc >= free_cyc)));
         chk("ram_we", int'(ram_we), int'(cyc == wr_cyc));
         if (cyc == wr_cyc) begin
            chk("ram_w_addr", int'(ram_w_addr), int'(wr_addr_exp));
            chk("bus_wdata", int'(ram_data), int'(wr_data_exp));
         end
         re_exp = (cyc >= rd_from) && (cyc <= rd_to);
         chk("ram_re", int'(ram_re), int'(re_exp));
         if (re_exp) begin
            k_s = cyc - rd_from;
            if (k_s > rd_beats - 1) k_s = rd_beats - 1;
            chk("ram_r_addr", int'(ram_r_addr), (rd_base + k_s) % 8);
         end
         chk("we_re_excl", int'(ram_we & ram_re), 0);
         chk("bus_contention", int'(ram_we & ram_drv_q), 0);
         if (cyc == rst_edge_cyc) begin
            chk("rst_w_addr", int'(ram_w_addr), 0);
            chk("rst_r_addr", int'(ram_r_addr), 0);
            chk("rst_rdata", int'(bus_if.rsp_rdata), 0);
            chk("rst_last", int'(bus_if.rsp_last), 0);
         end
         if (bus_if.rsp_valid) begin
            if (sb_q.size() == 0) begin
               chk("rsp_spurious", int'(bus_if.rsp_valid), 0);
            end else begin
               e = sb_q.pop_front();
               chk("rsp_rdata", int'(bus_if.rsp_rdata), int'(e.d));
               chk("rsp_last", int'(bus_if.rsp_last), int'(e.l));
               chk("rsp_cycle", cyc, e.c);
            end
         end else if (sb_q.size() > 0 && sb_q[0].c <= cyc) begin
            e = sb_q.pop_front();
            chk("rsp_missing", int'(bus_if.rsp_valid), 1);
         end
      end
      if (rst) begin
         armed        = 1'b1;
         free_cyc     = cyc + 1;
         rst_edge_cyc = cyc + 1;
         wr_cyc       = -1;
         rd_from      = -1;
         rd_to        = -2;
         sb_q.delete();
         for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0000;
      end else if (bus_if.req_valid && bus_if.req_ready) begin
         a_cyc = cyc + 1;
         nacc++;
         if (bus_if.req_write) begin
            wr_cyc      = a_cyc;
            wr_addr_exp = bus_if.req_addr;
            wr_data_exp = bus_if.req_wdata;
            ref_mem[bus_if.req_addr] = bus_if.req_wdata;
            free_cyc    = a_cyc + 1;
         end else begin
            rd_beats = int'(bus_if.req_len) + 1;
            rd_base  = int'(bus_if.req_addr);
            rd_from  = a_cyc;
            rd_to    = a_cyc + rd_beats;
            for (int k = 0; k < rd_beats; k++) begin
               e.d = ref_mem[(rd_base + k) % 8];
               e.l = (k == rd_beats - 1);
               e.c = a_cyc + 2 + k;
               sb_q.push_back(e);
            end
            free_cyc = a_cyc + rd_beats + 2;
         end
      end
      if (end_req || cyc > 20000) begin
         chk("watchdog", int'(cyc > 20000), 0);
         chk("queue_drained", sb_q.size(), 0);
         chk("accept_count", nacc, ndrv);
         chk("accept_timeouts", ntmo, 0);
         $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
         $finish;
      end
   end

   task automatic issue(input logic wr, input logic [2:0] addr, input logic [2:0] len,
                        input logic [15:0] data, input bit keep);
      bit ok;
      bus_if.req_valid = 1'b1;
      bus_if.req_write = wr;
      bus_if.req_addr  = addr;
      bus_if.req_len   = len;
      bus_if.req_wdata = data;
      ok = 1'b0;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(negedge clk);
         if (bus_if.req_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!ok) ntmo++;
      if (!keep) bus_if.req_valid = 1'b0;
      ndrv++;
   endtask

   task automatic idle(input int n);
      bus_if.req_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst              = 1'b1;
      bus_if.req_valid = 1'b0;
      bus_if.req_write = 1'b0;
      bus_if.req_addr  = 3'd0;
      bus_if.req_len   = 3'd0;
      bus_if.req_wdata = 16'h0000;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle(2);
      issue(1'b1, 3'd3, 3'd0, 16'hA5A5, 1'b0);
      issue(1'b0, 3'd3, 3'd0, 16'h0000, 1'b0);
      idle(4);
      for (int i = 0; i < 8; i++) issue(1'b1, 3'(i), 3'd0, 16'h1000 + 16'(i), 1'b0);
      issue(1'b0, 3'd6, 3'd7, 16'h0000, 1'b0);
      idle(2);
      // Read immediately followed by a write held on the bus.
      issue(1'b0, 3'd1, 3'd3, 16'h0000, 1'b1);
      issue(1'b1, 3'd2, 3'd0, 16'hBEEF, 1'b0);
      idle(2);
      // Reset during the second beat of a long burst.
      issue(1'b0, 3'd0, 3'd7, 16'h0000, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      issue(1'b0, 3'd0, 3'd7, 16'h0000, 1'b0);
      idle(12);
      for (int i = 0; i < 8; i++) begin
         issue((i % 2) == 0, 3'(i), 3'(i % 4), 16'($urandom), 1'b1);
      end
      idle(3);
      for (int i = 0; i < 150; i++) begin
         issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               16'($urandom), $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
      end
      idle(20);
      end_req = 1'b1;
   end

endmodule
